// File: rtl/cvxif_offload_queue.sv
// CV-X-IF offload engine: registered issue stage, outstanding-instruction table,
// commit/kill generation and a single-entry buffer for synthesised writebacks.
module cvxif_offload_queue #(
  parameter int unsigned NR_ENTRIES    = 4,
  parameter int unsigned TRANS_ID_BITS = 3,
  parameter int unsigned XLEN          = 64,
  parameter int unsigned NR_RS         = 3
) (
  input  logic                          clk_i,
  input  logic                          rst_i,
  input  logic                          flush_i,
  input  logic                          in_valid_i,
  output logic                          in_ready_o,
  input  logic [31:0]                   in_instr_i,
  input  logic [TRANS_ID_BITS-1:0]      in_trans_id_i,
  input  logic [NR_RS*XLEN-1:0]         in_rs_i,
  output logic                          x_issue_valid_o,
  input  logic                          x_issue_ready_i,
  output logic [31:0]                   x_issue_instr_o,
  output logic [TRANS_ID_BITS-1:0]      x_issue_id_o,
  output logic [NR_RS*XLEN-1:0]         x_issue_rs_o,
  output logic [NR_RS-1:0]              x_issue_rs_valid_o,
  input  logic                          x_issue_accept_i,
  input  logic                          x_issue_writeback_i,
  output logic                          x_commit_valid_o,
  output logic [TRANS_ID_BITS-1:0]      x_commit_id_o,
  output logic                          x_commit_kill_o,
  input  logic                          x_result_valid_i,
  output logic                          x_result_ready_o,
  input  logic [TRANS_ID_BITS-1:0]      x_result_id_i,
  input  logic [XLEN-1:0]               x_result_data_i,
  input  logic                          x_result_exc_i,
  output logic                          wb_valid_o,
  output logic [TRANS_ID_BITS-1:0]      wb_trans_id_o,
  output logic [XLEN-1:0]               wb_data_o,
  output logic                          wb_ex_valid_o,
  output logic [$clog2(NR_ENTRIES):0]   outstanding_o,
  output logic                          protocol_err_o
);

  localparam int unsigned CntW = $clog2(NR_ENTRIES) + 1;
  localparam int unsigned IdxW = $clog2(NR_ENTRIES);

  logic                     iss_valid_q, iss_valid_d;
  logic [31:0]              iss_instr_q, iss_instr_d;
  logic [TRANS_ID_BITS-1:0] iss_id_q, iss_id_d;
  logic [NR_RS*XLEN-1:0]    iss_rs_q, iss_rs_d;

  logic [NR_ENTRIES-1:0]    ent_valid_q, ent_valid_d;
  logic [NR_ENTRIES-1:0]    ent_sq_q, ent_sq_d;
  logic [TRANS_ID_BITS-1:0] ent_id_q [NR_ENTRIES];
  logic [TRANS_ID_BITS-1:0] ent_id_d [NR_ENTRIES];

  logic                     cpl_valid_q, cpl_valid_d;
  logic [TRANS_ID_BITS-1:0] cpl_id_q, cpl_id_d;
  logic                     cpl_ex_q, cpl_ex_d;

  logic                     commit_valid_q, commit_valid_d;
  logic [TRANS_ID_BITS-1:0] commit_id_q, commit_id_d;
  logic                     commit_kill_q, commit_kill_d;

  logic                     wb_valid_q, wb_valid_d;
  logic [TRANS_ID_BITS-1:0] wb_id_q, wb_id_d;
  logic [XLEN-1:0]          wb_data_q, wb_data_d;
  logic                     wb_ex_q, wb_ex_d;

  logic                     perr_q, perr_d;

  logic [CntW-1:0]          occ;
  logic                     hit, free_found;
  logic [IdxW-1:0]          hit_idx, free_idx;
  logic                     in_hs, iss_hs, res_hs;

  always_comb begin
    occ = '0;
    for (int i = 0; i < int'(NR_ENTRIES); i++) begin
      occ = occ + CntW'(ent_valid_q[i]);
    end
  end

  // Downward scan so the lowest matching / free slot wins.
  always_comb begin
    hit        = 1'b0;
    hit_idx    = '0;
    free_found = 1'b0;
    free_idx   = '0;
    for (int i = int'(NR_ENTRIES) - 1; i >= 0; i--) begin
      if (ent_valid_q[i] && (ent_id_q[i] == x_result_id_i)) begin
        hit     = 1'b1;
        hit_idx = IdxW'(i);
      end
      if (!ent_valid_q[i]) begin
        free_found = 1'b1;
        free_idx   = IdxW'(i);
      end
    end
  end

  assign in_ready_o         = !iss_valid_q && (occ < CntW'(NR_ENTRIES)) && !flush_i && !rst_i;
  // Held off while a synthesised writeback is pending so a second one cannot be lost.
  assign x_issue_valid_o    = iss_valid_q && !cpl_valid_q;
  assign x_issue_instr_o    = iss_instr_q;
  assign x_issue_id_o       = iss_id_q;
  assign x_issue_rs_o       = iss_rs_q;
  assign x_issue_rs_valid_o = {NR_RS{x_issue_valid_o}};
  assign x_result_ready_o   = !cpl_valid_q && (occ != '0);

  assign in_hs  = in_valid_i && in_ready_o;
  assign iss_hs = x_issue_valid_o && x_issue_ready_i;
  assign res_hs = x_result_valid_i && x_result_ready_o;

  always_comb begin
    iss_valid_d = iss_valid_q;
    iss_instr_d = iss_instr_q;
    iss_id_d    = iss_id_q;
    iss_rs_d    = iss_rs_q;
    if (flush_i) begin
      iss_valid_d = 1'b0;
    end else if (in_hs) begin
      iss_valid_d = 1'b1;
      iss_instr_d = in_instr_i;
      iss_id_d    = in_trans_id_i;
      iss_rs_d    = in_rs_i;
    end else if (iss_hs) begin
      iss_valid_d = 1'b0;
    end

    commit_valid_d = iss_hs;
    commit_id_d    = iss_hs ? iss_id_q : '0;
    commit_kill_d  = iss_hs && (!x_issue_accept_i || flush_i);

    wb_valid_d = 1'b0;
    wb_id_d    = '0;
    wb_data_d  = '0;
    wb_ex_d    = 1'b0;
    if (cpl_valid_q && !flush_i) begin
      wb_valid_d = 1'b1;
      wb_id_d    = cpl_id_q;
      wb_ex_d    = cpl_ex_q;
    end else if (res_hs && hit && !ent_sq_q[hit_idx] && !flush_i) begin
      wb_valid_d = 1'b1;
      wb_id_d    = x_result_id_i;
      wb_data_d  = x_result_data_i;
      wb_ex_d    = x_result_exc_i;
    end

    cpl_valid_d = 1'b0;
    cpl_id_d    = cpl_id_q;
    cpl_ex_d    = cpl_ex_q;
    if (iss_hs && !flush_i && (!x_issue_accept_i || !x_issue_writeback_i)) begin
      cpl_valid_d = 1'b1;
      cpl_id_d    = iss_id_q;
      cpl_ex_d    = !x_issue_accept_i;
    end

    ent_valid_d = ent_valid_q;
    ent_sq_d    = ent_sq_q | {NR_ENTRIES{flush_i}};
    ent_id_d    = ent_id_q;
    if (res_hs && hit) begin
      ent_valid_d[hit_idx] = 1'b0;
    end
    if (iss_hs && x_issue_accept_i && x_issue_writeback_i && free_found) begin
      ent_valid_d[free_idx] = 1'b1;
      ent_sq_d[free_idx]    = flush_i;
      ent_id_d[free_idx]    = iss_id_q;
    end

    perr_d = perr_q | (res_hs && !hit);
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      iss_valid_q    <= 1'b0;
      iss_instr_q    <= '0;
      iss_id_q       <= '0;
      iss_rs_q       <= '0;
      ent_valid_q    <= '0;
      ent_sq_q       <= '0;
      for (int i = 0; i < int'(NR_ENTRIES); i++) ent_id_q[i] <= '0;
      cpl_valid_q    <= 1'b0;
      cpl_id_q       <= '0;
      cpl_ex_q       <= 1'b0;
      commit_valid_q <= 1'b0;
      commit_id_q    <= '0;
      commit_kill_q  <= 1'b0;
      wb_valid_q     <= 1'b0;
      wb_id_q        <= '0;
      wb_data_q      <= '0;
      wb_ex_q        <= 1'b0;
      perr_q         <= 1'b0;
    end else begin
      iss_valid_q    <= iss_valid_d;
      iss_instr_q    <= iss_instr_d;
      iss_id_q       <= iss_id_d;
      iss_rs_q       <= iss_rs_d;
      ent_valid_q    <= ent_valid_d;
      ent_sq_q       <= ent_sq_d;
      ent_id_q       <= ent_id_d;
      cpl_valid_q    <= cpl_valid_d;
      cpl_id_q       <= cpl_id_d;
      cpl_ex_q       <= cpl_ex_d;
      commit_valid_q <= commit_valid_d;
      commit_id_q    <= commit_id_d;
      commit_kill_q  <= commit_kill_d;
      wb_valid_q     <= wb_valid_d;
      wb_id_q        <= wb_id_d;
      wb_data_q      <= wb_data_d;
      wb_ex_q        <= wb_ex_d;
      perr_q         <= perr_d;
    end
  end

  assign x_commit_valid_o = commit_valid_q;
  assign x_commit_id_o    = commit_id_q;
  assign x_commit_kill_o  = commit_kill_q;
  assign wb_valid_o       = wb_valid_q;
  assign wb_trans_id_o    = wb_id_q;
  assign wb_data_o        = wb_data_q;
  assign wb_ex_valid_o    = wb_ex_q;
  assign outstanding_o    = occ;
  assign protocol_err_o   = perr_q;

endmodule

// File: tb/tb_cvxif_offload_queue.sv
// Bench for cvxif_offload_queue: directed scenarios with literal expectations, then random
// traffic checked every cycle against a queue-based transaction model.
module tb_cvxif_offload_queue;
  localparam int NE = 4;
  localparam int XL = 64;
  localparam int NR = 3;

  logic clk_i = 1'b0;
  logic rst_i = 1'b1;
  logic flush_i = 1'b0;
  logic in_valid_i = 1'b0;
  logic in_ready_o;
  logic [31:0] in_instr_i = '0;
  logic [2:0] in_trans_id_i = '0;
  logic [NR*XL-1:0] in_rs_i = '0;
  logic x_issue_valid_o;
  logic x_issue_ready_i = 1'b0;
  logic [31:0] x_issue_instr_o;
  logic [2:0] x_issue_id_o;
  logic [NR*XL-1:0] x_issue_rs_o;
  logic [NR-1:0] x_issue_rs_valid_o;
  logic x_issue_accept_i = 1'b0;
  logic x_issue_writeback_i = 1'b0;
  logic x_commit_valid_o;
  logic [2:0] x_commit_id_o;
  logic x_commit_kill_o;
  logic x_result_valid_i = 1'b0;
  logic x_result_ready_o;
  logic [2:0] x_result_id_i = '0;
  logic [XL-1:0] x_result_data_i = '0;
  logic x_result_exc_i = 1'b0;
  logic wb_valid_o;
  logic [2:0] wb_trans_id_o;
  logic [XL-1:0] wb_data_o;
  logic wb_ex_valid_o;
  logic [2:0] outstanding_o;
  logic protocol_err_o;

  cvxif_offload_queue #(
    .NR_ENTRIES(NE), .TRANS_ID_BITS(3), .XLEN(XL), .NR_RS(NR)
  ) dut (
    .clk_i(clk_i), .rst_i(rst_i), .flush_i(flush_i),
    .in_valid_i(in_valid_i), .in_ready_o(in_ready_o), .in_instr_i(in_instr_i),
    .in_trans_id_i(in_trans_id_i), .in_rs_i(in_rs_i),
    .x_issue_valid_o(x_issue_valid_o), .x_issue_ready_i(x_issue_ready_i),
    .x_issue_instr_o(x_issue_instr_o), .x_issue_id_o(x_issue_id_o),
    .x_issue_rs_o(x_issue_rs_o), .x_issue_rs_valid_o(x_issue_rs_valid_o),
    .x_issue_accept_i(x_issue_accept_i), .x_issue_writeback_i(x_issue_writeback_i),
    .x_commit_valid_o(x_commit_valid_o), .x_commit_id_o(x_commit_id_o),
    .x_commit_kill_o(x_commit_kill_o),
    .x_result_valid_i(x_result_valid_i), .x_result_ready_o(x_result_ready_o),
    .x_result_id_i(x_result_id_i), .x_result_data_i(x_result_data_i),
    .x_result_exc_i(x_result_exc_i),
    .wb_valid_o(wb_valid_o), .wb_trans_id_o(wb_trans_id_o), .wb_data_o(wb_data_o),
    .wb_ex_valid_o(wb_ex_valid_o), .outstanding_o(outstanding_o),
    .protocol_err_o(protocol_err_o)
  );

  always #5 clk_i = ~clk_i;

  int n_checks = 0;
  int n_fail = 0;

  task automatic check(input string name, input logic [NR*XL-1:0] act,
                       input logic [NR*XL-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Transaction model: outstanding instructions as a list of {id, squashed}.
  typedef struct {
    logic [2:0] id;
    bit         sq;
  } ent_t;

  ent_t m_tab[$];
  bit m_iss_v = 0;
  logic [31:0] m_iss_instr = '0;
  logic [2:0] m_iss_id = '0;
  logic [NR*XL-1:0] m_iss_rs = '0;
  bit m_cpl_v = 0;
  logic [2:0] m_cpl_id = '0;
  bit m_cpl_ex = 0;
  bit e_cv = 0, e_ck = 0, e_wv = 0, e_wex = 0, e_perr = 0;
  logic [2:0] e_cid = '0, e_wid = '0;
  logic [XL-1:0] e_wdata = '0;

  task automatic model_reset();
    m_tab.delete();
    m_iss_v = 0; m_cpl_v = 0;
    e_cv = 0; e_ck = 0; e_cid = '0;
    e_wv = 0; e_wid = '0; e_wdata = '0; e_wex = 0;
    e_perr = 0;
  endtask

  task automatic model_step();
    bit iss_hs, res_hs, in_hs, hit;
    int hi;
    iss_hs = m_iss_v && !m_cpl_v && x_issue_ready_i;
    res_hs = x_result_valid_i && !m_cpl_v && (m_tab.size() != 0);
    in_hs  = in_valid_i && !m_iss_v && (m_tab.size() < NE) && !flush_i;
    hit = 0; hi = 0;
    foreach (m_tab[i]) if (!hit && m_tab[i].id == x_result_id_i) begin hit = 1; hi = i; end

    e_cv  = iss_hs;
    e_cid = iss_hs ? m_iss_id : 3'd0;
    e_ck  = iss_hs && (!x_issue_accept_i || flush_i);

    e_wv = 0; e_wid = '0; e_wdata = '0; e_wex = 0;
    if (m_cpl_v && !flush_i) begin
      e_wv = 1; e_wid = m_cpl_id; e_wex = m_cpl_ex;
    end else if (res_hs && hit && !m_tab[hi].sq && !flush_i) begin
      e_wv = 1; e_wid = x_result_id_i; e_wdata = x_result_data_i; e_wex = x_result_exc_i;
    end
    if (res_hs && !hit) e_perr = 1;
    if (res_hs && hit) m_tab.delete(hi);
    if (flush_i) foreach (m_tab[i]) m_tab[i].sq = 1;
    if (iss_hs && x_issue_accept_i && x_issue_writeback_i)
      m_tab.push_back('{id: m_iss_id, sq: flush_i});

    m_cpl_v = 0;
    if (iss_hs && !flush_i && (!x_issue_accept_i || !x_issue_writeback_i)) begin
      m_cpl_v = 1; m_cpl_id = m_iss_id; m_cpl_ex = !x_issue_accept_i;
    end

    if (flush_i) m_iss_v = 0;
    else if (in_hs) begin
      m_iss_v = 1; m_iss_instr = in_instr_i; m_iss_id = in_trans_id_i; m_iss_rs = in_rs_i;
    end else if (iss_hs) m_iss_v = 0;
  endtask

  always @(posedge clk_i or posedge rst_i) begin
    if (rst_i) model_reset();
    else model_step();
  end

  always @(negedge clk_i) begin
    bit xiv;
    xiv = m_iss_v && !m_cpl_v;
    check("in_ready", in_ready_o,
          !m_iss_v && (m_tab.size() < NE) && !flush_i && !rst_i);
    check("x_issue_valid", x_issue_valid_o, xiv);
    check("x_issue_rs_valid", x_issue_rs_valid_o, xiv ? 3'b111 : 3'b000);
    if (xiv) begin
      check("x_issue_instr", x_issue_instr_o, m_iss_instr);
      check("x_issue_id", x_issue_id_o, m_iss_id);
      check("x_issue_rs", x_issue_rs_o, m_iss_rs);
    end
    check("x_result_ready", x_result_ready_o, !m_cpl_v && (m_tab.size() != 0));
    check("commit", {x_commit_valid_o, x_commit_id_o, x_commit_kill_o}, {e_cv, e_cid, e_ck});
    check("wb", {wb_valid_o, wb_trans_id_o, wb_ex_valid_o}, {e_wv, e_wid, e_wex});
    check("wb_data", wb_data_o, e_wdata);
    check("outstanding", outstanding_o, m_tab.size());
    check("protocol_err", protocol_err_o, e_perr);
  end

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic send_in(input logic [2:0] id, input logic [31:0] instr);
    in_valid_i = 1; in_trans_id_i = id; in_instr_i = instr;
    in_rs_i = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
    tick();
    in_valid_i = 0;
  endtask

  task automatic send_res(input logic [2:0] id, input logic [XL-1:0] data, input logic exc);
    x_result_valid_i = 1; x_result_id_i = id; x_result_data_i = data; x_result_exc_i = exc;
    tick();
    x_result_valid_i = 0;
  endtask

  function automatic bit id_busy(input logic [2:0] id);
    if (m_iss_v && m_iss_id == id) return 1;
    foreach (m_tab[i]) if (m_tab[i].id == id) return 1;
    return 0;
  endfunction

  initial begin
    logic [XL-1:0] d;
    #1;
    check("rst_issue_valid", x_issue_valid_o, 0);
    check("rst_commit_valid", x_commit_valid_o, 0);
    check("rst_wb_valid", wb_valid_o, 0);
    check("rst_outstanding", outstanding_o, 0);
    check("rst_result_ready", x_result_ready_o, 0);
    check("rst_perr", protocol_err_o, 0);
    tick(); tick();
    rst_i = 0;

    // Single accepted instruction with writeback.
    x_issue_ready_i = 1; x_issue_accept_i = 1; x_issue_writeback_i = 1;
    send_in(3'd2, 32'h0000_002b);
    check("t1_issue_valid", x_issue_valid_o, 1);
    check("t1_issue_id", x_issue_id_o, 2);
    tick();
    check("t1_commit", {x_commit_valid_o, x_commit_id_o, x_commit_kill_o}, {1'b1, 3'd2, 1'b0});
    check("t1_outstanding", outstanding_o, 1);
    x_issue_ready_i = 0;
    send_res(3'd2, 64'hdead, 1'b0);
    check("t1_wb", {wb_valid_o, wb_trans_id_o, wb_ex_valid_o}, {1'b1, 3'd2, 1'b0});
    check("t1_wb_data", wb_data_o, 64'hdead);
    check("t1_outstanding_end", outstanding_o, 0);

    // Rejected instruction.
    x_issue_ready_i = 1; x_issue_accept_i = 0;
    send_in(3'd5, 32'h0000_105b);
    tick();
    check("t2_commit", {x_commit_valid_o, x_commit_id_o, x_commit_kill_o}, {1'b1, 3'd5, 1'b1});
    check("t2_outstanding", outstanding_o, 0);
    tick();
    check("t2_wb", {wb_valid_o, wb_trans_id_o, wb_ex_valid_o}, {1'b1, 3'd5, 1'b1});
    check("t2_wb_data", wb_data_o, 0);

    // Fill the table, then drain out of order.
    x_issue_accept_i = 1;
    for (int i = 0; i < NE; i++) begin
      send_in(3'(i), 32'h0000_200b + 32'(i));
      tick();
    end
    x_issue_ready_i = 0;
    check("t3_full_ready", in_ready_o, 0);
    check("t3_full_occ", outstanding_o, 4);
    check("t3_model_occ", m_tab.size(), 4);
    send_res(3'd1, 64'h1111_0000_0000_0001, 1'b0);
    check("t3_wb1", {wb_valid_o, wb_trans_id_o}, {1'b1, 3'd1});
    check("t3_wb1_data", wb_data_o, 64'h1111_0000_0000_0001);
    check("t3_ready_again", in_ready_o, 1);
    check("t3_occ3", outstanding_o, 3);
    send_res(3'd3, 64'h3333_0000_0000_0003, 1'b1);
    check("t3_wb3", {wb_valid_o, wb_trans_id_o, wb_ex_valid_o}, {1'b1, 3'd3, 1'b1});
    check("t3_wb3_data", wb_data_o, 64'h3333_0000_0000_0003);
    send_res(3'd0, 64'h0, 1'b0);
    check("t3_wb0", {wb_valid_o, wb_trans_id_o}, {1'b1, 3'd0});
    send_res(3'd2, 64'h2222_0000_0000_0002, 1'b0);
    check("t3_wb2_data", wb_data_o, 64'h2222_0000_0000_0002);
    check("t3_occ0", outstanding_o, 0);

    // Flush with two outstanding and one waiting in the issue register.
    x_issue_ready_i = 1;
    send_in(3'd4, 32'h0000_400b); tick();
    send_in(3'd5, 32'h0000_500b); tick();
    x_issue_ready_i = 0;
    send_in(3'd6, 32'h0000_600b);
    check("t4_held", x_issue_valid_o, 1);
    flush_i = 1;
    tick();
    flush_i = 0;
    check("t4_issue_dropped", x_issue_valid_o, 0);
    check("t4_occ2", outstanding_o, 2);
    send_res(3'd4, 64'h4444, 1'b0);
    check("t4_no_wb4", wb_valid_o, 0);
    check("t4_occ1", outstanding_o, 1);
    send_res(3'd5, 64'h5555, 1'b0);
    check("t4_no_wb5", wb_valid_o, 0);
    check("t4_occ0", outstanding_o, 0);

    // Result id matching nothing.
    x_issue_ready_i = 1;
    send_in(3'd3, 32'h0000_300b); tick();
    x_issue_ready_i = 0;
    x_result_valid_i = 1; x_result_id_i = 3'd7; x_result_data_i = 64'h77;
    check("t5_result_ready", x_result_ready_o, 1);
    tick();
    x_result_valid_i = 0;
    check("t5_no_wb", wb_valid_o, 0);
    check("t5_perr", protocol_err_o, 1);
    check("t5_occ", outstanding_o, 1);
    tick();
    check("t5_perr_sticky", protocol_err_o, 1);
    send_res(3'd3, 64'h3, 1'b0);
    check("t5_wb3", {wb_valid_o, wb_trans_id_o}, {1'b1, 3'd3});

    // Asynchronous reset between clock edges.
    x_issue_ready_i = 1;
    send_in(3'd1, 32'h0000_100b); tick();
    x_issue_ready_i = 0;
    send_in(3'd2, 32'h0000_200b);
    @(posedge clk_i);
    #3 rst_i = 1;
    #1;
    check("t6_issue_valid", x_issue_valid_o, 0);
    check("t6_rs_valid", x_issue_rs_valid_o, 0);
    check("t6_commit", x_commit_valid_o, 0);
    check("t6_wb", wb_valid_o, 0);
    check("t6_occ", outstanding_o, 0);
    check("t6_perr", protocol_err_o, 0);
    check("t6_in_ready", in_ready_o, 0);
    check("t6_result_ready", x_result_ready_o, 0);
    @(posedge clk_i);
    #3 rst_i = 0;
    tick();
    check("t6_occ_after", outstanding_o, 0);
    check("t6_in_ready_after", in_ready_o, 1);

    // Random traffic against the model.
    for (int c = 0; c < 3000; c++) begin
      logic [2:0] nid;
      flush_i = ($urandom % 40) == 0;
      nid = 3'($urandom_range(0, 7));
      in_valid_i = ($urandom % 2 == 0) && !id_busy(nid);
      in_trans_id_i = nid;
      in_instr_i = $urandom;
      in_rs_i = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
      x_issue_ready_i = ($urandom % 10) < 6;
      x_issue_accept_i = ($urandom % 4) != 0;
      x_issue_writeback_i = ($urandom % 4) != 0;
      x_result_valid_i = $urandom % 2 == 0;
      if (m_tab.size() != 0 && ($urandom % 10) != 0)
        x_result_id_i = m_tab[$urandom_range(0, m_tab.size() - 1)].id;
      else
        x_result_id_i = 3'($urandom_range(0, 7));
      d = {$urandom, $urandom};
      x_result_data_i = d;
      x_result_exc_i = ($urandom % 8) == 0;
      tick();
    end
    flush_i = 0; in_valid_i = 0; x_issue_ready_i = 0; x_result_valid_i = 0;
    tick(); tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
